// File: rtl/key_repeat_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : key_repeat_ctrl
//  Description : Synchronises and debounces two active-low push-buttons and
//                turns them into single-cycle increment/decrement strobes
//                with hold-to-repeat. A shared FSM owns the repeat timer and
//                locks out all pulses while both keys are involved.
//  Ports       : clk       - system clock (only clock)
//                rst_n     - asynchronous active-low reset
//                key1      - raw increase button, 0 = pressed
//                key2      - raw decrease button, 0 = pressed
//                inc_pulse - one-cycle increment strobe
//                dec_pulse - one-cycle decrement strobe
//                key1_held - debounced key1 level, 1 = pressed
//                key2_held - debounced key2 level, 1 = pressed
//  Revision    : 1.0 - initial release
// ============================================================================
module key_repeat_ctrl #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000,
   parameter int CNT_W           = 25
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key1,
   input  logic key2,
   output logic inc_pulse,
   output logic dec_pulse,
   output logic key1_held,
   output logic key2_held
);

   localparam logic [CNT_W-1:0] C_DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] C_PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

   logic [1:0] w_key_raw;   // index 0 = key1, 1 = key2; 1 = released
   logic [1:0] w_db;        // debounced level, 1 = released
   logic [1:0] w_held;      // registered inverse of w_db
   logic [1:0] w_pressed;
   logic [1:0] w_press_evt;

   assign w_key_raw = {key2, key1};

   // ------------------------------------------------------------------------
   // Per-key synchroniser and debouncer
   // ------------------------------------------------------------------------
   for (genvar k = 0; k < 2; k++) begin : g_key
      logic             sync1_q, sync1_d;
      logic             sync2_q, sync2_d;
      logic             db_q, db_d;
      logic             held_q, held_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;

      always_comb begin
         sync1_d = w_key_raw[k];
         sync2_d = sync1_q;
         held_d  = ~db_q;
         db_d    = db_q;
         cnt_d   = '0;
         if (sync2_q != db_q) begin
            if (cnt_q == C_DB_LAST) begin
               db_d = sync2_q;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            db_q    <= 1'b1;
            held_q  <= 1'b0;
            cnt_q   <= '0;
         end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            held_q  <= held_d;
            cnt_q   <= cnt_d;
         end
      end

      assign w_db[k]   = db_q;
      assign w_held[k] = held_q;
   end

   assign w_pressed   = ~w_db;
   // held_q still shows the previous db level, so this is the cycle right
   // after db went released -> pressed.
   assign w_press_evt = w_pressed & ~w_held;

   // ------------------------------------------------------------------------
   // Shared repeat FSM
   // ------------------------------------------------------------------------
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_DELAY   = 2'd1,
      S_REPEAT  = 2'd2,
      S_LOCKOUT = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic             owner_q, owner_d;   // 0 = key1, 1 = key2
   logic             inc_pulse_q, inc_pulse_d;
   logic             dec_pulse_q, dec_pulse_d;
   logic             w_emit;
   logic             w_other_pressed;
   logic             w_owner_pressed;

   assign w_owner_pressed = w_pressed[owner_q];
   assign w_other_pressed = w_pressed[~owner_q];

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      owner_d = owner_q;
      w_emit  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (w_press_evt[0] && !w_pressed[1]) begin
               w_emit  = 1'b1;
               owner_d = 1'b0;
               timer_d = '0;
               state_d = S_DELAY;
            end else if (w_press_evt[1] && !w_pressed[0]) begin
               w_emit  = 1'b1;
               owner_d = 1'b1;
               timer_d = '0;
               state_d = S_DELAY;
            end else if (|w_press_evt) begin
               // simultaneous press, or press while the other key is held
               state_d = S_LOCKOUT;
            end
         end
         S_DELAY, S_REPEAT: begin
            // exits take priority over timer expiry and never pulse
            if (w_other_pressed) begin
               timer_d = '0;
               state_d = S_LOCKOUT;
            end else if (!w_owner_pressed) begin
               timer_d = '0;
               state_d = S_IDLE;
            end else if (timer_q == ((state_q == S_DELAY) ? C_DLY_LAST : C_PER_LAST)) begin
               w_emit  = 1'b1;
               timer_d = '0;
               state_d = S_REPEAT;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_LOCKOUT: begin
            if (!w_pressed[0] && !w_pressed[1]) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            timer_d = '0;
         end
      endcase
      inc_pulse_d = w_emit & ~owner_d;
      dec_pulse_d = w_emit &  owner_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         timer_q     <= '0;
         owner_q     <= 1'b0;
         inc_pulse_q <= 1'b0;
         dec_pulse_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         owner_q     <= owner_d;
         inc_pulse_q <= inc_pulse_d;
         dec_pulse_q <= dec_pulse_d;
      end
   end

   assign inc_pulse = inc_pulse_q;
   assign dec_pulse = dec_pulse_q;
   assign key1_held = w_held[0];
   assign key2_held = w_held[1];

endmodule
`default_nettype wire

// File: tb/tb_key_repeat_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_repeat_ctrl
//  Description : Self-checking bench for key_repeat_ctrl. Expected pulse
//                times (absolute cycle * 2 + kind, kind 1 = dec) are queued
//                when keys are driven and compared as pulses appear.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_repeat_ctrl;

   localparam int D  = 4;
   localparam int RD = 10;
   localparam int RP = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic key1  = 1'b1;
   logic key2  = 1'b1;
   logic inc_pulse, dec_pulse, key1_held, key2_held;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int exp_q[$];
   bit key2_seen = 1'b0;

   key_repeat_ctrl #(
      .DEBOUNCE_CYCLES (D),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP),
      .CNT_W           (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key1      (key1),
      .key2      (key2),
      .inc_pulse (inc_pulse),
      .dec_pulse (dec_pulse),
      .key1_held (key1_held),
      .key2_held (key2_held)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic void exp_pulse(input int c, input bit dec);
      exp_q.push_back(c * 2 + int'(dec));
   endfunction

   // returns #1 after the edge that brings cyc to c
   task automatic wait_until(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic end_scn(input string tag);
      check(tag, exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_inc"},  inc_pulse, 0);
      check({tag, "_dec"},  dec_pulse, 0);
      check({tag, "_h1"},   key1_held, 0);
      check({tag, "_h2"},   key2_held, 0);
   endtask

   // pulse monitor / scoreboard
   always @(negedge clk) begin
      if (rst_n) begin
         key2_seen = key2_seen | key2_held;
         if (inc_pulse || dec_pulse) begin
            check("pulse_excl", inc_pulse & dec_pulse, 0);
            if (exp_q.size() == 0)
               check("unexpected_pulse", cyc * 2 + int'(dec_pulse), 32'hFFFF_FFFF);
            else
               check("pulse_time", cyc * 2 + int'(dec_pulse), exp_q.pop_front());
         end
      end
   end

   initial begin
      int t0, t1;

      // ---- reset state
      wait_until(2);
      check_idle_outputs("reset");
      rst_n = 1'b1;
      wait_until(5);

      // ---- single tap on key1
      t0 = cyc;
      key1 = 1'b0;
      exp_pulse(t0 + D + 3, 1'b0);
      wait_until(t0 + 6);  check("tap_held_e6",  key1_held, 0);
      wait_until(t0 + 7);  check("tap_held_e7",  key1_held, 1);
      wait_until(t0 + 8);  key1 = 1'b1;
      wait_until(t0 + 14); check("tap_held_e14", key1_held, 1);
      wait_until(t0 + 15); check("tap_held_e15", key1_held, 0);
      wait_until(t0 + 30);
      end_scn("tap_missing");

      // ---- bounce on key2
      key2_seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         key2 = 1'b0;
         wait_until(cyc + 2);
         key2 = 1'b1;
         wait_until(cyc + 2);
      end
      wait_until(cyc + 20);
      check("bounce_held", key2_seen, 0);
      end_scn("bounce_missing");

      // ---- hold key1 for 40 cycles
      t0 = cyc;
      key1 = 1'b0;
      exp_pulse(t0 + 7, 1'b0);
      for (int p = t0 + 7 + RD; p <= t0 + 40 + D + 2; p += RP) exp_pulse(p, 1'b0);
      wait_until(t0 + 40); key1 = 1'b1;
      wait_until(t0 + 46); check("hold_rel_e46", key1_held, 1);
      wait_until(t0 + 47); check("hold_rel_e47", key1_held, 0);
      wait_until(t0 + 60);
      end_scn("hold_missing");

      // ---- conflict: key2 pressed while key1 repeats
      t0 = cyc;
      key1 = 1'b0;
      exp_pulse(t0 + 7,  1'b0);
      exp_pulse(t0 + 17, 1'b0);
      exp_pulse(t0 + 20, 1'b0);
      exp_pulse(t0 + 23, 1'b0);
      wait_until(t0 + 18); key2 = 1'b0;
      wait_until(t0 + 30);
      check("conf_h2", key2_held, 1);
      key1 = 1'b1;
      wait_until(t0 + 35); key2 = 1'b1;
      wait_until(t0 + 50);
      t1 = cyc;
      key2 = 1'b0;
      exp_pulse(t1 + 7, 1'b1);
      wait_until(t1 + 8);  key2 = 1'b1;
      wait_until(t1 + 25);
      end_scn("conf_missing");

      // ---- simultaneous press
      t0 = cyc;
      key1 = 1'b0;
      key2 = 1'b0;
      wait_until(t0 + 10);
      check("sim_h1", key1_held, 1);
      check("sim_h2", key2_held, 1);
      wait_until(t0 + 20);
      key1 = 1'b1;
      key2 = 1'b1;
      wait_until(t0 + 40);
      end_scn("sim_missing");

      // ---- reset mid-REPEAT with key1 held
      t0 = cyc;
      key1 = 1'b0;
      exp_pulse(t0 + 7,  1'b0);
      exp_pulse(t0 + 17, 1'b0);
      exp_pulse(t0 + 20, 1'b0);
      wait_until(t0 + 21);
      rst_n = 1'b0;
      #1;
      check_idle_outputs("rst_async");
      wait_until(t0 + 23);
      check_idle_outputs("rst_hold");
      check("rst_pre_pulses", exp_q.size(), 0);
      t1 = cyc;
      rst_n = 1'b1;
      exp_pulse(t1 + 7, 1'b0);
      for (int p = t1 + 7 + RD; p <= t1 + 22 + D + 2; p += RP) exp_pulse(p, 1'b0);
      wait_until(t1 + 22); key1 = 1'b1;
      wait_until(t1 + 40);
      end_scn("rst_missing");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/key_repeat_ctrl.md
# key_repeat_ctrl

Front-end for the increase/decrease counter. It takes the two raw active-low push-buttons `key1` (increase) and `key2` (decrease), then synchronises and debounces them. It produces clean single-cycle `inc_pulse`/`dec_pulse` strobes with hold-to-repeat, which the downstream counter consumes directly on `clk` in place of sampling raw key levels on a divided clock.

## Interface

- `DEBOUNCE_CYCLES`, 500000: consecutive stable samples required to accept a key change (10 ms at 50 MHz); ≥1.
- `REPEAT_DELAY`, 25000000: cycles from the first pulse to the first auto-repeat pulse; ≥1.
- `REPEAT_PERIOD`, 5000000: cycles between subsequent auto-repeat pulses; ≥1.
- `CNT_W`, 25: width of the debounce and repeat timers; must hold the largest of the three counts minus 1.

- `clk` in 1: system clock; the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `key1` in 1: raw increase button, asynchronous, 0 = pressed.
- `key2` in 1: raw decrease button, asynchronous, 0 = pressed.
- `inc_pulse` out 1: one-cycle increment strobe.
- `dec_pulse` out 1: one-cycle decrement strobe.
- `key1_held` out 1: debounced key1 level, 1 = pressed.
- `key2_held` out 1: debounced key2 level, 1 = pressed.

## Operation

- **Synchroniser:** two flops per key, reset to 1 (released).
- **Debouncer, per key:**
  - Keeps a debounced state `db` (reset: released) and a counter (reset: 0).
  - While the synchronised input differs from `db`, the counter increments.
  - On the edge where the counter equals `DEBOUNCE_CYCLES-1` and the input still differs, `db` flips and the counter clears.
  - Any sample equal to `db` clears the counter.
  - A press event is a `db` transition from released to pressed.
- **Repeat FSM, shared:** states IDLE, DELAY, REPEAT, LOCKOUT. It has one repeat timer (reset: 0) and an owner bit.
  - **IDLE:**
    - Key1 press event while key2 is released: emit `inc_pulse`, owner = key1, timer = 0, go to DELAY.
    - Key2 press event while key1 is released: symmetric, emitting `dec_pulse`.
    - Press events on both keys in the same cycle, or a press event while the other key is already held: go to LOCKOUT with no pulse.
  - **DELAY:** timer increments. When it reaches `REPEAT_DELAY-1`, emit the owner's pulse, clear the timer and go to REPEAT.
  - **REPEAT:** timer increments. When it reaches `REPEAT_PERIOD-1`, emit the owner's pulse and clear the timer.
  - **Exit priority in DELAY and REPEAT** (checked before timer expiry; no pulse on an exit cycle):
    - The other key is debounced-pressed (including the same cycle the owner releases): go to LOCKOUT.
    - Otherwise, the owner is released: go to IDLE.
  - **LOCKOUT:** no pulses. Go to IDLE once both keys are debounced-released.
- `inc_pulse` and `dec_pulse` are registered, never both high, and each is high for exactly one cycle per emission.
- `keyN_held` is the registered inverse of that key's `db`.

## Timing

- **Reset values:** all outputs 0, FSM in IDLE, all counters 0, synchronisers and `db` released.
- **Press latency:**
  - Counting the first edge that samples `keyN` low as edge 1, `db` flips at edge `DEBOUNCE_CYCLES+2`.
  - `keyN_held` rises at edge `DEBOUNCE_CYCLES+3`.
  - The first pulse is high during the cycle following edge `DEBOUNCE_CYCLES+3`.
- **Repeat cadence:** the first repeat pulse comes `REPEAT_DELAY` cycles after the first pulse; later pulses come every `REPEAT_PERIOD` cycles.
- **Release latency:** `keyN_held` falls `DEBOUNCE_CYCLES+3` edges after the raw release, with the same counting as press latency.
- **Glitches:** any input glitch shorter than `DEBOUNCE_CYCLES` synchronised samples produces no `db` change.
- **Reset mid-operation:** clears everything asynchronously. A key still held when `rst_n` deasserts is debounced afresh and yields a new first pulse after the press latency.
- **Timer wrap:** timers never exceed their terminal count, so no wrap is possible.

## Test plan

Bench parameters: `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=3.

- **Single tap:** key1 low for 8 cycles, then high → exactly one `inc_pulse`, high in the cycle after edge 7; `key1_held` spans edges 7 to 14; no `dec_pulse`.
- **Bounce:** key2 toggles every 2 cycles for 20 cycles, then stays high → no `dec_pulse`, `key2_held` stays 0.
- **Hold:** key1 low for 40 cycles → pulses at relative cycles 0, 10, 13, 16, … while held (cycle 0 = first pulse); pulses stop on the first cycle `db` reads released.
- **Conflict:** hold key1 into REPEAT, then press key2 → no pulses after key2 debounces, FSM in LOCKOUT until both are released; next key2 tap gives one `dec_pulse`.
- **Simultaneous:** key1 and key2 go low on the same edge → zero pulses while held; `key1_held` = `key2_held` = 1.
- **Reset:** assert `rst_n`=0 mid-REPEAT with key1 held, release `rst_n` → outputs 0 during reset; first `inc_pulse` 7 edges after release, then the repeat sequence restarts.
